clm_mod_p_unit: RTL and testbench

Multi-lane iterative reduction and refresh unit for redundant CLM field elements. Each lane holds an (8+D)-bit element, an 8-bit GF(2^8) value plus D redundant bits, relative to the run-time base polynomial P. Reduce mode folds the element modulo P into the canonical 8-bit value; refresh mode adds a random multiple r·P to re-randomise the representation. It replaces the fixed single-width MOD_P step. The cipher controller uses it in the MOD_P stage and for mid-round state refresh.

---
 rtl/clm_mod_p_unit.sv | 128 ++++++++++++
 tb/tb_clm_mod_p_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clm_mod_p_unit.sv
// Multi-lane iterative reduce / refresh unit for redundant CLM field elements.
// One polynomial step per cycle per lane; D steps fold or re-randomise against P.
module clm_mod_p_unit #(
  parameter int D     = 4,
  parameter int LANES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         drdy_i,
  input  logic                         mode,
  input  logic [0:8]                   P,
  input  logic [LANES-1:0][0:7+D]      in,
  input  logic [LANES-1:0][0:D-1]      r,
  output logic [LANES-1:0][0:7+D]      out,
  output logic                         drdy_o,
  output logic                         busy,
  output logic                         p_err
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0][0:7+D]     acc_q, acc_d;
  logic [LANES-1:0][0:7+D]     acc_step;
  logic [LANES-1:0][0:7+D]     out_q, out_d;
  logic [LANES-1:0][0:D-1]     r_q, r_d;
  logic [0:7]                  p_q, p_d;
  logic                        mode_q, mode_d;
  logic                        drdy_q, drdy_d;
  logic                        busy_q, busy_d;
  logic                        perr_q, perr_d;
  logic [0:8]                  p_eff;
  logic                        last_step;

  // Leading coefficient is forced to 1 so the top term always cancels.
  assign p_eff     = {1'b1, p_q};
  assign last_step = (cnt_q == CW'(D - 1));

  always_comb begin
    acc_step = acc_q;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < D; k++) begin
        if (int'(cnt_q) == k) begin
          if (mode_q ? r_q[l][k] : acc_q[l][k]) begin
            for (int j = 0; j < 9; j++) begin
              acc_step[l][k+j] = acc_q[l][k+j] ^ p_eff[j];
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    r_d     = r_q;
    p_d     = p_q;
    mode_d  = mode_q;
    drdy_d  = 1'b0;
    busy_d  = busy_q;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: begin
        if (drdy_i) begin
          acc_d   = in;
          r_d     = r;
          p_d     = P[1:8];
          mode_d  = mode;
          perr_d  = ~P[0];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        if (last_step) begin
          out_d   = acc_step;
          drdy_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      r_q     <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      r_q     <= r_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      drdy_q  <= drdy_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  assign out    = out_q;
  assign drdy_o = drdy_q;
  assign busy   = busy_q;
  assign p_err  = perr_q;

endmodule

// File: tb/tb_clm_mod_p_unit.sv
// Directed-vector bench for clm_mod_p_unit with D=4, LANES=2 and the AES polynomial.
module tb_clm_mod_p_unit;

  typedef logic [1:0][0:11] vec_t;
  typedef logic [1:0][0:3]  rv_t;

  logic       clk;
  logic       rst;
  logic       drdy_i;
  logic       mode;
  logic [0:8] p_in;
  vec_t       din;
  rv_t        rin;
  vec_t       dout;
  logic       drdy_o;
  logic       busy;
  logic       p_err;

  int n_vec = 0;
  int n_err = 0;

  clm_mod_p_unit #(.D(4), .LANES(2)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .mode(mode), .P(p_in),
    .in(din), .r(rin), .out(dout), .drdy_o(drdy_o), .busy(busy), .p_err(p_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation, scrambles the inputs after capture, and reports what came back.
  task automatic run_op(input vec_t iv, input rv_t rv, input logic [0:8] pv, input logic mv,
                        output vec_t res, output int lat, output int busy_cyc,
                        output logic perr_cap, output logic dbl);
    @(negedge clk);
    din = iv; rin = rv; p_in = pv; mode = mv; drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i = 1'b0;
    din = ~iv; rin = ~rv; p_in = ~pv; mode = ~mv;
    perr_cap = p_err;
    busy_cyc = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (drdy_o) begin
        lat = i;
        break;
      end
      if (busy) busy_cyc++;
    end
    res = dout;
    @(posedge clk); #1;
    dbl = drdy_o;
  endtask

  task automatic test_reset();
    n_vec++; if (dout !== 24'h0) begin n_err++; $display("FAIL reset_out got=%h exp=%h", dout, 24'h0); end
    n_vec++; if (drdy_o !== 1'b0) begin n_err++; $display("FAIL reset_drdy got=%b exp=0", drdy_o); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (p_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", p_err); end
  endtask

  task automatic test_reduce_basic();
    vec_t res; int lat, bc; logic pe, dbl;
    run_op({12'h100, 12'h11B}, '0, 9'h11B, 1'b0, res, lat, bc, pe, dbl);
    n_vec++; if (res !== {12'h01B, 12'h000}) begin n_err++; $display("FAIL basic_out got=%h exp=%h", res, {12'h01B, 12'h000}); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    n_vec++; if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    n_vec++; if (dbl !== 1'b0) begin n_err++; $display("FAIL basic_single_pulse got=%b exp=0", dbl); end
    n_vec++; if (pe !== 1'b0) begin n_err++; $display("FAIL basic_perr got=%b exp=0", pe); end
  endtask

  task automatic test_reduce_high();
    vec_t res; int lat, bc; logic pe, dbl;
    run_op({12'h800, 12'h053}, '0, 9'h11B, 1'b0, res, lat, bc, pe, dbl);
    n_vec++; if (res !== {12'h0D8, 12'h053}) begin n_err++; $display("FAIL high_out got=%h exp=%h", res, {12'h0D8, 12'h053}); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL high_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_refresh_roundtrip();
    vec_t res, res2; int lat, bc; logic pe, dbl;
    run_op({12'h053, 12'h053}, {4'b0001, 4'b1000}, 9'h11B, 1'b1, res, lat, bc, pe, dbl);
    n_vec++; if (res !== {12'h148, 12'h88B}) begin n_err++; $display("FAIL refresh_out got=%h exp=%h", res, {12'h148, 12'h88B}); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL refresh_latency got=%0d exp=4", lat); end
    run_op(res, 8'hFF, 9'h11B, 1'b0, res2, lat, bc, pe, dbl);
    n_vec++; if (res2 !== {12'h053, 12'h053}) begin n_err++; $display("FAIL roundtrip_out got=%h exp=%h", res2, {12'h053, 12'h053}); end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    @(negedge clk);
    din = {12'h100, 12'h11B}; rin = '0; p_in = 9'h11B; mode = 1'b0; drdy_i = 1'b1;
    @(posedge clk); #1; drdy_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    din = {12'h800, 12'h053}; drdy_i = 1'b1;
    @(posedge clk); #1; drdy_i = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (drdy_o !== 1'b1) begin n_err++; $display("FAIL ignore_done got=%b exp=1", drdy_o); end
    n_vec++; if (dout !== {12'h01B, 12'h000}) begin n_err++; $display("FAIL ignore_out got=%h exp=%h", dout, {12'h01B, 12'h000}); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (drdy_o) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL ignore_extra_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int p[3] = '{-1, -1, -1};
    int n = 0;
    @(negedge clk);
    din = {12'h100, 12'h11B}; rin = '0; p_in = 9'h11B; mode = 1'b0; drdy_i = 1'b1;
    for (int cyc = 0; cyc <= 14; cyc++) begin
      @(posedge clk); #1;
      if (drdy_o) begin
        if (n < 3) p[n] = cyc;
        n++;
      end
    end
    drdy_i = 1'b0;
    n_vec++; if (n !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", n); end
    n_vec++; if (p[0] !== 4) begin n_err++; $display("FAIL b2b_first got=%0d exp=4", p[0]); end
    n_vec++; if (p[1] !== 9) begin n_err++; $display("FAIL b2b_second got=%0d exp=9", p[1]); end
    n_vec++; if (p[2] !== 14) begin n_err++; $display("FAIL b2b_third got=%0d exp=14", p[2]); end
    n_vec++; if (dout !== {12'h01B, 12'h000}) begin n_err++; $display("FAIL b2b_out got=%h exp=%h", dout, {12'h01B, 12'h000}); end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    vec_t res; int lat, bc; logic pe, dbl;
    int pulses = 0;
    @(negedge clk);
    din = {12'h800, 12'h053}; rin = '0; p_in = 9'h01B; mode = 1'b0; drdy_i = 1'b1;
    @(posedge clk); #1; drdy_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++; if (dout !== 24'h0) begin n_err++; $display("FAIL midrst_out got=%h exp=%h", dout, 24'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_vec++; if (p_err !== 1'b0) begin n_err++; $display("FAIL midrst_perr got=%b exp=0", p_err); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (drdy_o) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
    run_op({12'h800, 12'h053}, '0, 9'h11B, 1'b0, res, lat, bc, pe, dbl);
    n_vec++; if (res !== {12'h0D8, 12'h053}) begin n_err++; $display("FAIL midrst_next_out got=%h exp=%h", res, {12'h0D8, 12'h053}); end
    n_vec++; if (lat !== 4) begin n_err++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_p_err();
    vec_t res; int lat, bc; logic pe, dbl;
    run_op({12'h100, 12'h11B}, '0, 9'h01B, 1'b0, res, lat, bc, pe, dbl);
    n_vec++; if (pe !== 1'b1) begin n_err++; $display("FAIL perr_capture got=%b exp=1", pe); end
    n_vec++; if (res !== {12'h01B, 12'h000}) begin n_err++; $display("FAIL perr_out got=%h exp=%h", res, {12'h01B, 12'h000}); end
    n_vec++; if (p_err !== 1'b1) begin n_err++; $display("FAIL perr_held got=%b exp=1", p_err); end
    run_op({12'h800, 12'h053}, '0, 9'h11B, 1'b0, res, lat, bc, pe, dbl);
    n_vec++; if (pe !== 1'b0) begin n_err++; $display("FAIL perr_clear got=%b exp=0", pe); end
    n_vec++; if (res !== {12'h0D8, 12'h053}) begin n_err++; $display("FAIL perr_next_out got=%h exp=%h", res, {12'h0D8, 12'h053}); end
  endtask

  initial begin
    rst = 1'b1; drdy_i = 1'b0; mode = 1'b0; p_in = 9'h11B; din = '0; rin = '0;
    #3;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reduce_basic();
    test_reduce_high();
    test_refresh_roundtrip();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_p_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
